// File: rtl/perf_pkg.sv
// Shared types and constants for the perf-event dump controller and its counter bank.
package perf_pkg;

  localparam int PERF_CYCLE_W     = 64;
  localparam int PERF_ID_MAX_W    = 16;
  localparam int PERF_VALUE_MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } perf_state_t;

  // Widest form of one dump record; instances use the low bits they need.
  typedef struct packed {
    logic [PERF_ID_MAX_W-1:0]    id;
    logic [PERF_VALUE_MAX_W-1:0] value;
    logic [PERF_CYCLE_W-1:0]     cycle;
    logic                        last;
  } perf_record_t;

  function automatic int perf_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perf_event_bank.sv
// Bank of per-event wrapping counters with capture-and-clear read access.
// PERF_SNAPSHOT_EN selects an all-at-once snapshot into shadow registers.
module perf_event_bank
  import perf_pkg::*;
#(
  parameter int  NUM_EVENTS = 8,
  parameter int  CNT_WIDTH  = 32,
  localparam int IDX_W      = perf_idx_w(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_inc,
`ifdef PERF_SNAPSHOT_EN
  input  logic                  snap_en,
`else
  input  logic                  cap_en,
`endif
  input  logic [IDX_W-1:0]      cap_idx,
  output logic [CNT_WIDTH-1:0]  cap_value
);

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] clr;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS];

  assign clr = {NUM_EVENTS{snap_en}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow_q[i] <= '0;
    end else if (snap_en) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow_q[i] <= cnt_q[i];
    end
  end

  // The first record reads the live counter because the shadow loads on that same edge.
  assign cap_value = snap_en ? cnt_q[cap_idx] : shadow_q[cap_idx];
`else
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    clr = '0;
    for (int i = 0; i < NUM_EVENTS; i++) clr[i] = cap_en && (cap_idx == IDX_W'(i));
  end

  assign cap_value = cnt_q[cap_idx];
`endif

  // NOTE: the counters are interval state, not storage, so they are reset with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++)
        cnt_q[i] <= (clr[i] ? '0 : cnt_q[i]) + CNT_WIDTH'(event_inc[i]);
    end
  end

endmodule

// File: rtl/perf_dump_ctrl.sv
// Periodic / on-request dump of a perf counter bank over one valid/ready record port.
// PERF_SNAPSHOT_EN: all counters snapshot at dump start instead of per-record capture.
module perf_dump_ctrl
  import perf_pkg::*;
#(
  parameter int  NUM_EVENTS = 8,
  parameter int  CNT_WIDTH  = 32,
  parameter int  INTERVAL   = 1024,
  localparam int IDX_W      = perf_idx_w(NUM_EVENTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_EVENTS-1:0]   event_inc,
  input  logic                    dump_req,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_id,
  output logic [CNT_WIDTH-1:0]    out_value,
  output logic [PERF_CYCLE_W-1:0] out_cycle,
  output logic                    out_last
);

  localparam int                 TIMER_W    = (INTERVAL < 2) ? 1 : $clog2(INTERVAL);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((INTERVAL == 0) ? 0 : INTERVAL - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_EVENTS - 1);
  localparam bit                 AUTO_EN    = (INTERVAL != 0);

  perf_state_t             state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TIMER_W-1:0]      timer_q;
  logic                    pending_q;
  logic [PERF_CYCLE_W-1:0] cyc_q;
  logic                    busy_q;
  logic                    valid_q;
  logic [IDX_W-1:0]        id_q;
  logic [CNT_WIDTH-1:0]    value_q;
  logic [PERF_CYCLE_W-1:0] cycle_q;
  logic                    last_q;

  logic                 auto_hit;
  logic                 start;
  logic                 hs;
  logic                 rec_load;
  logic [IDX_W-1:0]     next_idx;
  logic [CNT_WIDTH-1:0] cap_value;

  assign auto_hit = AUTO_EN && (timer_q == TIMER_LAST);
  assign start    = (state_q == IDLE) && (dump_req || pending_q || auto_hit);
  assign hs       = (state_q == DUMP) && valid_q && out_ready;
  // A record is presented on dump start or on any handshake that is not the last one.
  assign rec_load = start || (hs && (idx_q != LAST_IDX));
  assign next_idx = start ? '0 : idx_q + IDX_W'(1);

  perf_event_bank #(
    .NUM_EVENTS(NUM_EVENTS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .event_inc(event_inc),
`ifdef PERF_SNAPSHOT_EN
    .snap_en  (start),
`else
    .cap_en   (rec_load),
`endif
    .cap_idx  (next_idx),
    .cap_value(cap_value)
  );

  // NOTE: <= throughout so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      cyc_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      value_q   <= '0;
      cycle_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      cyc_q <= cyc_q + PERF_CYCLE_W'(1);
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= DUMP;
            busy_q    <= 1'b1;
            valid_q   <= 1'b1;
            timer_q   <= '0;
            pending_q <= 1'b0;
            cycle_q   <= cyc_q;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        DUMP: begin
          if (dump_req) pending_q <= 1'b1;
          if (hs && (idx_q == LAST_IDX)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (rec_load) begin
        idx_q   <= next_idx;
        id_q    <= next_idx;
        value_q <= cap_value;
        last_q  <= (next_idx == LAST_IDX);
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign out_value = value_q;
  assign out_cycle = cycle_q;
  assign out_last  = last_q;

endmodule
